// File: rtl/cordic_serial_bridge.sv
// cordic_serial_bridge: parallel <-> bit-serial adapter for the CORDIC core with a show-ahead result FIFO.
// Define CORDIC_BRIDGE_CREDIT_EN to throttle input by FIFO credits so no result is ever dropped.
module cordic_serial_bridge #(
  parameter int WIDTH      = 16,
  parameter int PIPE_SLOTS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  input  logic             in_rot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_z,
  input  logic             core_valid,
  output logic             core_xi,
  output logic             core_yi,
  output logic             core_zi,
  output logic             core_rot,
  input  logic             core_xo,
  input  logic             core_yo,
  input  logic             core_zo,
  output logic             drop_err
);
  localparam int BW = $clog2(WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic                  rdy_q, stg_full, stg_rot, srot, stag;
  logic [WIDTH-1:0]      stg_x, stg_y, stg_z, sx, sy, sz, ox, oy, oz, nx, ny, nz;
  logic [BW-1:0]         bcnt;
  logic [PIPE_SLOTS-1:0] tags;
  logic [WIDTH-1:0]      fx [FIFO_DEPTH];
  logic [WIDTH-1:0]      fy [FIFO_DEPTH];
  logic [WIDTH-1:0]      fz [FIFO_DEPTH];
  logic [AW:0]           wp, rp;
  logic                  acc, slot_end, preload, push, pop, full, wr;
  assign acc      = in_valid & in_ready;
  assign slot_end = core_valid & (bcnt == BW'(WIDTH - 1));
  // An idle bubble slot that has not started yet is replaced by a waiting word, bypassing staging if needed
  assign preload  = ~core_valid & (bcnt == '0) & ~stag & (stg_full | acc);
  assign nx       = {core_xo, ox[WIDTH-1:1]};
  assign ny       = {core_yo, oy[WIDTH-1:1]};
  assign nz       = {core_zo, oz[WIDTH-1:1]};
  assign push     = slot_end & tags[PIPE_SLOTS-1];
  assign pop      = out_valid & out_ready;
  assign full     = (wp - rp) == (AW + 1)'(FIFO_DEPTH);
  assign wr       = push & (~full | pop);
  assign out_valid = wp != rp;
  assign out_x    = out_valid ? fx[rp[AW-1:0]] : '0;
  assign out_y    = out_valid ? fy[rp[AW-1:0]] : '0;
  assign out_z    = out_valid ? fz[rp[AW-1:0]] : '0;
  assign core_xi  = sx[0];
  assign core_yi  = sy[0];
  assign core_zi  = sz[0];
  assign core_rot = srot;
`ifdef CORDIC_BRIDGE_CREDIT_EN
  logic [AW:0] credits;
  assign in_ready = rdy_q & ~stg_full & (credits < (AW + 1)'(FIFO_DEPTH));
  assign drop_err = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) credits <= '0;
    else credits <= credits + (AW + 1)'(acc) - (AW + 1)'(pop);
`else
  logic drop_q;
  assign in_ready = rdy_q & ~stg_full;
  assign drop_err = drop_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) drop_q <= 1'b0;
    else if (push & full & ~pop) drop_q <= 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      stg_full <= 1'b0;
      stg_x    <= '0;
      stg_y    <= '0;
      stg_z    <= '0;
      stg_rot  <= 1'b0;
      sx       <= '0;
      sy       <= '0;
      sz       <= '0;
      srot     <= 1'b0;
      stag     <= 1'b0;
      bcnt     <= '0;
      ox       <= '0;
      oy       <= '0;
      oz       <= '0;
      tags     <= '0;
      wp       <= '0;
      rp       <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (acc & ~preload) begin
        stg_full <= 1'b1;
        stg_x    <= in_x;
        stg_y    <= in_y;
        stg_z    <= in_z;
        stg_rot  <= in_rot;
      end else if ((slot_end | preload) & stg_full) stg_full <= 1'b0;
      if (slot_end) begin
        sx   <= stg_full ? stg_x : '0;
        sy   <= stg_full ? stg_y : '0;
        sz   <= stg_full ? stg_z : '0;
        srot <= stg_full & stg_rot;
        stag <= stg_full;
        tags <= PIPE_SLOTS'({tags, stag});
      end else if (preload) begin
        sx   <= stg_full ? stg_x : in_x;
        sy   <= stg_full ? stg_y : in_y;
        sz   <= stg_full ? stg_z : in_z;
        srot <= stg_full ? stg_rot : in_rot;
        stag <= 1'b1;
      end else if (core_valid) begin
        sx <= {1'b0, sx[WIDTH-1:1]};
        sy <= {1'b0, sy[WIDTH-1:1]};
        sz <= {1'b0, sz[WIDTH-1:1]};
      end
      if (core_valid) begin
        ox   <= nx;
        oy   <= ny;
        oz   <= nz;
        bcnt <= slot_end ? '0 : bcnt + 1'b1;
      end
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end
  // At full with a pop, the write index equals the head index, so the new word lands behind the rest
  always_ff @(posedge clk)
    if (wr) begin
      fx[wp[AW-1:0]] <= nx;
      fy[wp[AW-1:0]] <= ny;
      fz[wp[AW-1:0]] <= nz;
    end
endmodule

// File: tb/tb_cordic_serial_bridge.sv
// tb_cordic_serial_bridge: scoreboard bench with a slot-level core model (loopback or ideal CORDIC).
module tb_cordic_serial_bridge;
  localparam int W = 16;
  localparam int P = 1;
  localparam int D = 4;
  localparam real K = 1.6467602581;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         in_valid = 1'b0, in_rot = 1'b0, out_ready = 1'b0, core_valid = 1'b0;
  logic [W-1:0] in_x = '0, in_y = '0, in_z = '0;
  logic         in_ready, out_valid, core_xi, core_yi, core_zi, core_rot, core_xo, core_yo, core_zo, drop_err;
  logic [W-1:0] out_x, out_y, out_z;
  always #5 clk = ~clk;
  cordic_serial_bridge #(.WIDTH(W), .PIPE_SLOTS(P), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_rot(in_rot),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .core_valid(core_valid), .core_xi(core_xi), .core_yi(core_yi), .core_zi(core_zi), .core_rot(core_rot),
    .core_xo(core_xo), .core_yo(core_yo), .core_zo(core_zo), .drop_err(drop_err)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask
  function automatic logic [W-1:0] near(input logic [W-1:0] got, input logic [W-1:0] want, input int t);
    int d;
    d = int'($signed(got)) - int'($signed(want));
    return (d <= t && d >= -t) ? want : got;
  endfunction
  // core model: collects one word per slot, emits its result P slots later, LSB first
  logic use_cordic = 1'b0;
  logic [3:0]   cbit;
  logic [W-1:0] cx, cy, cz;
  logic [W-1:0] px [P];
  logic [W-1:0] py [P];
  logic [W-1:0] pz [P];
  function automatic logic [W-1:0] to_fx(input real v);
    int i;
    i = $rtoi(v * 16384.0);
    return i[W-1:0];
  endfunction
  function automatic logic [3*W-1:0] core_fn(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z, input logic r);
    real xr, yr, zr, a, b, c;
    if (!use_cordic) return {x, y, z};
    xr = $itor($signed(x)) / 16384.0;
    yr = $itor($signed(y)) / 16384.0;
    zr = $itor($signed(z)) / 16384.0;
    if (r) begin
      a = K * (xr * $cos(zr) - yr * $sin(zr));
      b = K * (yr * $cos(zr) + xr * $sin(zr));
      c = 0.0;
    end else begin
      a = K * $sqrt(xr * xr + yr * yr);
      b = 0.0;
      c = zr + $atan2(yr, xr);
    end
    return {to_fx(a), to_fx(b), to_fx(c)};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cbit <= '0;
      cx <= '0;
      cy <= '0;
      cz <= '0;
      for (int p = 0; p < P; p++) begin
        px[p] <= '0;
        py[p] <= '0;
        pz[p] <= '0;
      end
    end else if (core_valid) begin
      cx <= {core_xi, cx[W-1:1]};
      cy <= {core_yi, cy[W-1:1]};
      cz <= {core_zi, cz[W-1:1]};
      cbit <= cbit + 1'b1;
      if (cbit == 4'(W - 1)) begin
        cbit <= '0;
        {px[0], py[0], pz[0]} <= core_fn({core_xi, cx[W-1:1]}, {core_yi, cy[W-1:1]}, {core_zi, cz[W-1:1]}, core_rot);
        for (int p = 1; p < P; p++) begin
          px[p] <= px[p-1];
          py[p] <= py[p-1];
          pz[p] <= pz[p-1];
        end
      end
    end
  assign core_xo = px[P-1][cbit];
  assign core_yo = py[P-1][cbit];
  assign core_zo = pz[P-1][cbit];
  // core_valid generator: 0 off, 1 gapless, 2 five on / three off, 3 finish current slot then stop
  int mode = 0;
  initial begin
    int g;
    g = 0;
    forever begin
      @(posedge clk);
      #1;
      g = (g + 1) % 8;
      core_valid = mode == 1 ? 1'b1 : mode == 2 ? (g < 5) : mode == 3 ? (cbit != 0) : 1'b0;
    end
  end
  typedef struct { logic [W-1:0] x, y, z; int tol; } sb_t;
  sb_t exp_q[$];
  sb_t mon_e;
  int  pops = 0;
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("out_x", near(out_x, mon_e.x, mon_e.tol), mon_e.x);
        chk("out_y", near(out_y, mon_e.y, mon_e.tol), mon_e.y);
        chk("out_z", near(out_z, mon_e.z, mon_e.tol), mon_e.z);
      end
    end
  task automatic push_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z, input int t);
    sb_t e;
    e.x = x;
    e.y = y;
    e.z = z;
    e.tol = t;
    exp_q.push_back(e);
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic set_mode(input int m);
    @(negedge clk);
    mode = m;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                      input logic r, input int budget, output bit ok);
    in_x = x;
    in_y = y;
    in_z = z;
    in_rot = r;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask
  task automatic send_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z, input logic r);
    bit ok;
    send(x, y, z, r, 8 * W, ok);
    chk("accept", ok, 1);
    if (ok) push_exp(x, y, z, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int  lat, p0, acc;
    bit  ok;
    logic [W-1:0] wx;
    cyc(3);
    chk("rst_outs", {in_ready, out_valid, drop_err, core_xi, core_yi, core_zi, core_rot, out_x, out_y, out_z}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_before_clk", in_ready, 0);
    cyc(1);
    chk("ready_after_clk", in_ready, 1);
    // single word, gapless loopback, latency and single pulse
    out_ready = 1'b1;
    in_x = 16'h1234;
    in_y = 16'hF000;
    in_z = 16'h0001;
    in_rot = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("t1_ready", in_ready, 1);
    mode = 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_exp(16'h1234, 16'hF000, 16'h0001, 0);
    p0 = pops;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk("t1_latency", lat, (P + 1) * W + 1);
    cyc(3 * W);
    chk("t1_pulses", pops - p0, 1);
    // four back-to-back words with gapped core_valid
    set_mode(2);
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      wx = W'($urandom);
      send_exp(wx, ~wx, wx ^ 16'h5A5A, 1'(i));
    end
    for (int i = 0; i < 80 * W && pops - p0 < 4; i++) cyc(1);
    cyc(4 * W);
    chk("t2_count", pops - p0, 4);
    chk("t2_q_empty", exp_q.size(), 0);
    // ideal CORDIC core, rotate and vector
    set_mode(1);
    use_cordic = 1'b1;
    p0 = pops;
    send(16'h26DD, 16'h0000, 16'h1921, 1'b1, 8 * W, ok);
    chk("t3_rot_accept", ok, 1);
    push_exp(16'h3B21, 16'h187E, 16'h0000, 8);
    send(16'h1000, 16'h1000, 16'h0000, 1'b0, 8 * W, ok);
    chk("t3_vec_accept", ok, 1);
    push_exp(16'h2543, 16'h0000, 16'h3243, 8);
    cyc(5 * W);
    chk("t3_count", pops - p0, 2);
    use_cordic = 1'b0;
`ifndef CORDIC_BRIDGE_CREDIT_EN
    // full FIFO with a push and a pop on the same edge
    out_ready = 1'b0;
    for (int i = 0; i < D; i++) send_exp(16'h1100 + 16'(i), 16'h2200 + 16'(i), 16'h3300 + 16'(i), 1'b0);
    cyc(3 * W);
    set_mode(3);
    cyc(2 * W);
    chk("t6_fill_valid", out_valid, 1);
    send(16'hBEEF, 16'hCAFE, 16'h0F0F, 1'b1, 4, ok);
    chk("t6_preload_accept", ok, 1);
    push_exp(16'hBEEF, 16'hCAFE, 16'h0F0F, 0);
    @(negedge clk);
    mode = 1;
    @(posedge clk);
    #1;
    p0 = pops;
    cyc((P + 1) * W - 1);
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    @(negedge clk);
    chk("t6_no_drop", drop_err, 0);
    chk("t6_one_pop", pops - p0, 1);
    chk("t6_still_valid", out_valid, 1);
    @(posedge clk);
    #1;
    p0 = pops;
    out_ready = 1'b1;
    cyc(2 * W);
    chk("t6_occupancy", pops - p0, D);
`endif
    // overflow with out_ready held low
    out_ready = 1'b0;
    set_mode(1);
    acc = 0;
    p0 = pops;
    for (int i = 0; i < 6; i++) begin
      send(16'h4000 + 16'(i), 16'h0100 * 16'(i), 16'h7000 - 16'(i), 1'b1, 4 * W, ok);
      if (ok) begin
        acc++;
        if (acc <= D) push_exp(16'h4000 + 16'(i), 16'h0100 * 16'(i), 16'h7000 - 16'(i), 0);
      end
    end
    cyc(4 * W);
`ifdef CORDIC_BRIDGE_CREDIT_EN
    chk("t4_accepts", acc, D);
    chk("t4_ready_low", in_ready, 0);
    chk("t4_drop", drop_err, 0);
`else
    chk("t4_accepts", acc, 6);
    chk("t4_drop", drop_err, 1);
`endif
    out_ready = 1'b1;
    cyc(2 * W);
    chk("t4_results", pops - p0, D);
`ifdef CORDIC_BRIDGE_CREDIT_EN
    send_exp(16'h0404, 16'h0505, 16'h0606, 1'b0);
    send_exp(16'h0707, 16'h0808, 16'h0909, 1'b1);
    cyc(4 * W);
    chk("t4_late_results", pops - p0, D + 2);
`endif
    // asynchronous reset with two words in flight
    send(16'hAAAA, 16'h5555, 16'h0F0F, 1'b1, 4 * W, ok);
    send(16'h1357, 16'h2468, 16'h9ABC, 1'b0, 4 * W, ok);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      if (cbit == 4'd7) break;
    end
    chk("t5_bcnt7", cbit, 7);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {in_ready, out_valid, drop_err, core_xi, core_yi, core_zi, core_rot, out_x, out_y, out_z}, 0);
    exp_q.delete();
    cyc(3);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    p0 = pops;
    cyc(4 * W);
    chk("t5_no_out", pops - p0, 0);
    send_exp(16'h0C0D, 16'hE0F0, 16'h8001, 1'b1);
    cyc(4 * W);
    chk("t5_after_reset", pops - p0, 1);
    chk("final_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cordic_serial_bridge.md
# cordic_serial_bridge

Host-side adapter for the bit-serial CORDIC core. It accepts parallel x/y/z/rot words over a valid/ready handshake and serializes them LSB-first onto the core's serial inputs, framed by the core's `valid` strobe. It also deserializes the core's serial outputs into parallel result words, buffered in a small show-ahead FIFO. It sits between a parallel datapath and the `cordic` core and discards the result slots produced from idle (bubble) input slots.

## Interface
- `WIDTH`, 16, bits per word (signed fixed point, 0x4000 = 1.0)
- `PIPE_SLOTS`, 1, core latency in word slots between input slot and matching output slot (≥1)
- `FIFO_DEPTH`, 4, result FIFO entries (power of two, ≥2)

- `clk` in 1: single clock
- `rst_n` in 1: asynchronous active-low reset
- `in_valid` in 1, `in_ready` out 1: input word handshake
- `in_x`, `in_y`, `in_z` in WIDTH, `in_rot` in 1: operand words and mode (1 = rotate, 0 = vector)
- `out_valid` out 1, `out_ready` in 1: result handshake
- `out_x`, `out_y`, `out_z` out WIDTH: result words
- `core_valid` in 1: core bit strobe; one serial bit per cycle while high
- `core_xi`, `core_yi`, `core_zi` out 1, `core_rot` out 1: serial operands and mode to core
- `core_xo`, `core_yo`, `core_zo` in 1: serial results from core
- `drop_err` out 1: sticky, a result was lost to a full FIFO

## Operation
- Staging register holds one accepted word. `in_ready` = staging empty (AND credit available when enabled). Accept on `in_valid & in_ready`.
- Slot register: three WIDTH shift registers plus rot and a tag bit (1 = real, 0 = bubble). `core_xi/yi/zi` = bit 0 of each register. `core_rot` = slot rot.
- Bit counter `bcnt` runs 0..WIDTH-1:
  - Increments only on cycles with `core_valid` high.
  - Holds when `core_valid` is low. A mid-slot gap pauses the slot and does not abort it.
- On each `core_valid` cycle:
  - Slot registers shift right.
  - Output registers shift in MSB-first position: `{core_xo, sr[WIDTH-1:1]}`, likewise for y and z.
- Slot end is a `core_valid` cycle with `bcnt == WIDTH-1`. On slot end:
  - The slot register loads from staging (tag 1), or loads zeros with tag 0 if staging is empty.
  - A staging word accepted in the same cycle is not used. It waits for the next slot.
  - The tag pipeline (PIPE_SLOTS deep) shifts in the outgoing slot tag.
  - The completed output word is pushed to the FIFO only if the tag leaving the pipeline is 1.
- Idle preload: when `bcnt == 0`, `core_valid` is low, the slot tag is 0 and staging is full, the slot register loads from staging immediately. The first word after idle therefore rides the next slot.
- FIFO: show-ahead. `out_*` reflects the head entry. Pop on `out_valid & out_ready`. A simultaneous push and pop at full is legal.
- Full FIFO on push: the word is discarded and `drop_err` sets. It clears only on reset.

## Timing
- Reset values:
  - Every output and register is 0, including `core_*`, `out_*`, `out_valid`, `drop_err`, `bcnt`, the tag pipeline, FIFO pointers and credits.
  - `in_ready` is 0 during reset and rises on the first clock after deassertion.
- The core must be reset concurrently. Slot alignment assumes `bcnt == 0` at the core's first `valid` cycle.
- Input: a word accepted in cycle t drives bit 0 on `core_xi` from the next slot start (or t+1 via idle preload).
- Output: push occurs at the clock edge ending the last bit of the result slot. `out_valid` is high the following cycle.
- Minimum end-to-end latency with a gapless `core_valid` is (PIPE_SLOTS+1)·WIDTH + 1 cycles.
- Asynchronous reset mid-slot aborts all in-flight words. No partial result is ever emitted.

## Configuration
- `CORDIC_BRIDGE_CREDIT_EN` defined:
  - A credit counter increments on input accept and decrements on output pop.
  - `in_ready` additionally requires credits < FIFO_DEPTH, so no result is ever dropped.
  - `drop_err` is tied 0.
- Undefined: no credit logic. The input is throttled only by staging, and results arriving at a full FIFO are dropped with `drop_err` set.

## Test plan
- Loopback model (xo = xi delayed PIPE_SLOTS slots), `core_valid` gapless, words x=0x1234, y=0xF000, z=0x0001 -> identical words on `out_*`, one `out_valid` pulse, latency (PIPE_SLOTS+1)·16+1 cycles.
- Loopback, 4 back-to-back words, `core_valid` with 3-cycle gaps every 5 bits -> 4 results in order, no bubbles emitted, bits intact.
- Real `cordic` core, rotate, x=0x26DD, y=0, z=0x1921 -> out_x≈0x3B21 and out_y≈0x187E, each within ±8 LSB. Vector, x=y=0x1000 -> out_z≈0x3243 within ±8 LSB.
- `out_ready`=0, 6 words offered: with the macro, `in_ready` drops after 4 accepts and all 4 results appear when `out_ready` rises. Without the macro, `drop_err`=1 and the FIFO holds exactly 4 results.
- Assert `rst_n`=0 at `bcnt`=7 with 2 words in flight -> all outputs 0 immediately, no `out_valid` after release, next word processes correctly.
- Full FIFO with simultaneous push and pop -> no drop, occupancy unchanged, order preserved.
